// File: rtl/inc_dec_arbiter.sv
// inc_dec_arbiter: round-robin arbiter granting four requesters single inc/dec steps on a shared mirrored counter
// Ports: set (clock), reset (async active-low), req[3:0] step requests, dir[3:0] per-requester direction (1=dec),
//        clr clear request; gnt/ack one-hot registered grant/completion, step/ctrl counter strobe and direction,
//        clr_out clear strobe, out[WIDTH-1:0] mirrored count.
// Build option: define INC_DEC_ARBITER_SAT_EN to saturate at the count limits instead of wrapping.
module inc_dec_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             set,
  input  logic             reset,
  input  logic [3:0]       req,
  input  logic [3:0]       dir,
  input  logic             clr,
  output logic [3:0]       gnt,
  output logic [3:0]       ack,
  output logic             step,
  output logic             ctrl,
  output logic             clr_out,
  output logic [WIDTH-1:0] out
);
  typedef enum logic [1:0] {IDLE, GRANT, STEP, DONE} state_t;
  state_t           r_state, w_state;
  logic [1:0]       r_ptr, w_ptr, r_win, w_win, w_idx, w_c;
  logic             r_dir, w_dir, w_found, w_sat;
  logic [3:0]       w_gnt, w_ack;
  logic             w_step, w_ctrl, w_clr_out;
  logic [WIDTH-1:0] w_out;
`ifdef INC_DEC_ARBITER_SAT_EN
  // a step that would cross a limit is dropped; the operation still completes with an ack
  assign w_sat = r_dir ? (out == '0) : (out == '1);
`else
  assign w_sat = 1'b0;
`endif
  always_comb begin
    w_state   = r_state;
    w_ptr     = r_ptr;
    w_win     = r_win;
    w_dir     = r_dir;
    w_gnt     = '0;
    w_ack     = '0;
    w_step    = 1'b0;
    w_ctrl    = 1'b0;
    w_clr_out = 1'b0;
    w_out     = out;
    w_found   = 1'b0;
    w_idx     = '0;
    w_c       = '0;
    // first requesting index at or after the pointer, wrapping modulo 4
    for (int k = 0; k < 4; k++) begin
      w_c = r_ptr + 2'(k);
      if (!w_found && req[w_c]) begin
        w_found = 1'b1;
        w_idx   = w_c;
      end
    end
    case (r_state)
      IDLE: begin
        if (clr) begin
          w_clr_out = 1'b1;
          w_out     = '0;
        end else if (w_found) begin
          w_win   = w_idx;
          w_dir   = dir[w_idx];
          w_gnt   = 4'b0001 << w_idx;
          w_state = GRANT;
        end
      end
      GRANT: begin
        w_step  = !w_sat;
        w_ctrl  = !w_sat && r_dir;
        w_state = STEP;
      end
      STEP: begin
        w_out   = step ? (ctrl ? out - WIDTH'(1) : out + WIDTH'(1)) : out;
        w_ack   = 4'b0001 << r_win;
        w_state = DONE;
      end
      default: begin
        w_ptr   = r_win + 2'd1;
        w_state = IDLE;
      end
    endcase
  end
  always_ff @(posedge set or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_win   <= '0;
      r_dir   <= 1'b0;
      gnt     <= '0;
      ack     <= '0;
      step    <= 1'b0;
      ctrl    <= 1'b0;
      clr_out <= 1'b0;
      out     <= '0;
    end else begin
      r_state <= w_state;
      r_ptr   <= w_ptr;
      r_win   <= w_win;
      r_dir   <= w_dir;
      gnt     <= w_gnt;
      ack     <= w_ack;
      step    <= w_step;
      ctrl    <= w_ctrl;
      clr_out <= w_clr_out;
      out     <= w_out;
    end
  end
endmodule
